fwd_table_lookup: RTL and testbench

FWD_TABLE_LOOKUP -- requirements
Module: fwd_table_lookup

---
 rtl/fwd_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/fwd_table_lookup.sv | 241 ++++++++++++++++++++++++
 tb/tb_fwd_table_lookup.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding-table lookup block.
package fwd_pkg;

  // Default number of forwarders sharing one lookup engine.
  localparam int IF_COUNT_DEFAULT = 3;

  // Action encoding carried in each table entry and on resp_action.
  localparam logic ACT_DROP = 1'b0;
  localparam logic ACT_FWD  = 1'b1;

  // One forwarding-table entry.
  typedef struct packed {
    logic        valid;
    logic [31:0] prefix;
    logic [5:0]  len;
    logic        action;
    logic [1:0]  out_if;
  } fwd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_t;

  // Top `len` bits set. A logical right shift by 32 or more yields zero, so
  // any len above 32 naturally produces the full /32 mask.
  function automatic logic [31:0] prefix_mask(input logic [5:0] len);
    return ~(32'hFFFF_FFFF >> len);
  endfunction

  // Prefix length used for longest-match ranking; anything above 32 acts as 32.
  function automatic logic [5:0] eff_len(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, searching from the
// port after the last one that was accepted.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  // Index of the highest-priority port for the next grant.
  logic [PW-1:0] ptr_q, ptr_d;

  // Pick the first requester at or after ptr_q, wrapping modulo N.
  always_comb begin
    int   s;
    logic found;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    s         = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N) s = s - N;
      if (!found && req[PW'(s)]) begin
        grant[PW'(s)] = 1'b1;
        grant_idx     = PW'(s);
        found         = 1'b1;
      end
    end
  end

  // Once a grant is accepted, the port after it becomes highest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Pointer register; reset makes port 0 highest priority.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fwd_table_lookup.sv
// Forwarding-table lookup: IF_COUNT forwarders share one engine that scans
// ENTRIES entries one per cycle and returns the longest-prefix match.
// Optional build macro FWD_TABLE_STATS_EN adds saturating hit/miss counters.
module fwd_table_lookup
  import fwd_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IF_COUNT = IF_COUNT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IF_COUNT-1:0]        req_valid,
  input  logic [32*IF_COUNT-1:0]     req_ip,
  output logic [IF_COUNT-1:0]        req_ready,
  output logic [IF_COUNT-1:0]        resp_valid,
  output logic                       resp_hit,
  output logic                       resp_action,
  output logic [1:0]                 resp_out_if,
  output logic [$clog2(ENTRIES)-1:0] resp_index,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] cfg_wr_addr,
  input  logic                       cfg_wr_valid,
  input  logic [31:0]                cfg_wr_prefix,
  input  logic [5:0]                 cfg_wr_len,
  input  logic                       cfg_wr_action,
  input  logic [1:0]                 cfg_wr_out_if
`ifdef FWD_TABLE_STATS_EN
  ,
  output logic [31:0]                stat_hit_count,
  output logic [31:0]                stat_miss_count
`endif
);

  localparam int AW = $clog2(ENTRIES);
  localparam int PW = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1;

  fsm_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   ip_q, ip_d;
  logic [PW-1:0] port_q, port_d;

  // Best match found so far in the current scan.
  logic          best_hit_q, best_hit_d;
  logic [5:0]    best_len_q, best_len_d;
  logic [AW-1:0] best_idx_q, best_idx_d;
  logic          best_action_q, best_action_d;
  logic [1:0]    best_out_if_q, best_out_if_d;

  // Registered response outputs.
  logic [IF_COUNT-1:0] resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic                resp_action_q, resp_action_d;
  logic [1:0]          resp_out_if_q, resp_out_if_d;
  logic [AW-1:0]       resp_index_q, resp_index_d;

  fwd_entry_t table_q [ENTRIES];

  logic [IF_COUNT-1:0] grant;
  logic [PW-1:0]       grant_idx;
  logic                idle;
  logic                handshake;
  logic [31:0]         sel_ip;
  fwd_entry_t          cur;
  logic [5:0]          cur_len;
  logic                cur_match;

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  rr_arbiter #(.N(IF_COUNT)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Address of the granted requester, chosen by the one-hot grant.
  always_comb begin
    sel_ip = '0;
    for (int i = 0; i < IF_COUNT; i++) begin
      if (grant[i]) sel_ip = req_ip[i*32 +: 32];
    end
  end

  // Compare the entry under the scan index against the latched address.
  always_comb begin
    cur       = table_q[idx_q];
    cur_len   = eff_len(cur.len);
    cur_match = cur.valid &&
                ((ip_q & prefix_mask(cur.len)) == (cur.prefix & prefix_mask(cur.len)));
  end

  // Next-state logic for the IDLE -> SCAN -> RESP sequence and result capture.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ip_d          = ip_q;
    port_d        = port_q;
    best_hit_d    = best_hit_q;
    best_len_d    = best_len_q;
    best_idx_d    = best_idx_q;
    best_action_d = best_action_q;
    best_out_if_d = best_out_if_q;
    resp_valid_d  = '0;
    resp_hit_d    = resp_hit_q;
    resp_action_d = resp_action_q;
    resp_out_if_d = resp_out_if_q;
    resp_index_d  = resp_index_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          ip_d          = sel_ip;
          port_d        = grant_idx;
          idx_d         = '0;
          best_hit_d    = 1'b0;
          best_len_d    = '0;
          best_idx_d    = '0;
          best_action_d = ACT_DROP;
          best_out_if_d = '0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strictly longer wins, so an equal length keeps the lower index.
        if (cur_match && (!best_hit_q || cur_len > best_len_q)) begin
          best_hit_d    = 1'b1;
          best_len_d    = cur_len;
          best_idx_d    = idx_q;
          best_action_d = cur.action;
          best_out_if_d = cur.out_if;
        end
        if (idx_q == AW'(ENTRIES - 1)) state_d = ST_RESP;
        else                           idx_d   = idx_q + AW'(1);
      end
      ST_RESP: begin
        resp_valid_d  = IF_COUNT'(1) << port_q;
        resp_hit_d    = best_hit_q;
        resp_action_d = best_hit_q ? best_action_q : ACT_DROP;
        resp_out_if_d = best_hit_q ? best_out_if_q : 2'd0;
        resp_index_d  = best_hit_q ? best_idx_q : '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, scan and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      ip_q          <= '0;
      port_q        <= '0;
      best_hit_q    <= 1'b0;
      best_len_q    <= '0;
      best_idx_q    <= '0;
      best_action_q <= ACT_DROP;
      best_out_if_q <= '0;
      resp_valid_q  <= '0;
      resp_hit_q    <= 1'b0;
      resp_action_q <= ACT_DROP;
      resp_out_if_q <= '0;
      resp_index_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ip_q          <= ip_d;
      port_q        <= port_d;
      best_hit_q    <= best_hit_d;
      best_len_q    <= best_len_d;
      best_idx_q    <= best_idx_d;
      best_action_q <= best_action_d;
      best_out_if_q <= best_out_if_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_action_q <= resp_action_d;
      resp_out_if_q <= resp_out_if_d;
      resp_index_q  <= resp_index_d;
    end
  end

  // Table storage: writes land on the next edge, so an in-flight compare
  // always sees the pre-write contents of its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the valid bits are reset; prefix/len/action/out_if are don't-care while invalid.
      for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (cfg_wr_en) begin
      table_q[cfg_wr_addr] <= '{valid:  cfg_wr_valid,
                                prefix: cfg_wr_prefix,
                                len:    cfg_wr_len,
                                action: cfg_wr_action,
                                out_if: cfg_wr_out_if};
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_action = resp_action_q;
  assign resp_out_if = resp_out_if_q;
  assign resp_index  = resp_index_q;

`ifdef FWD_TABLE_STATS_EN
  logic [31:0] stat_hit_count_q, stat_hit_count_d;
  logic [31:0] stat_miss_count_q, stat_miss_count_d;

  // One count per completed lookup, saturating at all-ones.
  always_comb begin
    stat_hit_count_d  = stat_hit_count_q;
    stat_miss_count_d = stat_miss_count_q;
    if (state_q == ST_RESP) begin
      if (best_hit_q) begin
        if (stat_hit_count_q != 32'hFFFF_FFFF) stat_hit_count_d = stat_hit_count_q + 32'd1;
      end else begin
        if (stat_miss_count_q != 32'hFFFF_FFFF) stat_miss_count_d = stat_miss_count_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hit_count_q  <= '0;
      stat_miss_count_q <= '0;
    end else begin
      stat_hit_count_q  <= stat_hit_count_d;
      stat_miss_count_q <= stat_miss_count_d;
    end
  end

  assign stat_hit_count  = stat_hit_count_q;
  assign stat_miss_count = stat_miss_count_q;
`else
  // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_fwd_table_lookup.sv
// Self-checking bench for fwd_table_lookup: a per-cycle reference model plus
// directed scenarios with hand-computed results.
module tb_fwd_table_lookup;

  localparam int ENTRIES = 16;
  localparam int N       = 3;
  localparam int AW      = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_ip;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic              resp_hit;
  logic              resp_action;
  logic [1:0]        resp_out_if;
  logic [AW-1:0]     resp_index;
  logic              cfg_wr_en;
  logic [AW-1:0]     cfg_wr_addr;
  logic              cfg_wr_valid;
  logic [31:0]       cfg_wr_prefix;
  logic [5:0]        cfg_wr_len;
  logic              cfg_wr_action;
  logic [1:0]        cfg_wr_out_if;
`ifdef FWD_TABLE_STATS_EN
  logic [31:0]       stat_hit_count;
  logic [31:0]       stat_miss_count;
`endif

  fwd_table_lookup #(.ENTRIES(ENTRIES), .IF_COUNT(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ip        (req_ip),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_action   (resp_action),
    .resp_out_if   (resp_out_if),
    .resp_index    (resp_index),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_valid  (cfg_wr_valid),
    .cfg_wr_prefix (cfg_wr_prefix),
    .cfg_wr_len    (cfg_wr_len),
    .cfg_wr_action (cfg_wr_action),
    .cfg_wr_out_if (cfg_wr_out_if)
`ifdef FWD_TABLE_STATS_EN
    ,
    .stat_hit_count  (stat_hit_count),
    .stat_miss_count (stat_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        valid;
    bit [31:0] prefix;
    int        len;
    bit        action;
    bit [1:0]  out_if;
  } m_entry_t;

  m_entry_t  m_tbl [ENTRIES];   // table as written so far
  m_entry_t  scan_tbl [ENTRIES]; // per-entry view the pending lookup will compare
  int        m_last;
  bit        pend;
  int        pend_cyc;
  int        pend_port;
  bit [31:0] pend_ip;
  int        busy_until;
  bit        h_hit, h_act;
  bit [1:0]  h_oif;
  int        h_idx;

  function automatic bit m_match(input m_entry_t e, input bit [31:0] ip);
    int        l;
    bit [31:0] mask;
    l    = (e.len > 32) ? 32 : e.len;
    mask = '0;
    for (int b = 0; b < l; b++) mask[31-b] = 1'b1;
    return e.valid && (((ip ^ e.prefix) & mask) == 32'd0);
  endfunction

  function automatic void m_lookup(input bit [31:0] ip, output bit hit, output bit act,
                                   output bit [1:0] oif, output int idx);
    int best, best_len, l;
    best = -1; best_len = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_match(scan_tbl[i], ip)) begin
        l = (scan_tbl[i].len > 32) ? 32 : scan_tbl[i].len;
        if (l > best_len) begin best = i; best_len = l; end
      end
    end
    hit = (best >= 0);
    act = hit ? scan_tbl[best].action : 1'b0;
    oif = hit ? scan_tbl[best].out_if : 2'd0;
    idx = hit ? best : 0;
  endfunction

  function automatic bit [N-1:0] m_grant(input bit [N-1:0] req);
    int p;
    bit [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      p = (m_last + 1 + k) % N;
      if (req[p]) begin g[p] = 1'b1; return g; end
    end
    return g;
  endfunction

  bit [N-1:0] mon_exp_ready, mon_exp_rv;
  m_entry_t   mon_e;

  // Compare process: every cycle outside reset, all outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) m_tbl[i].valid = 1'b0;
      m_last = N - 1; pend = 1'b0; busy_until = 0;
      h_hit = 1'b0; h_act = 1'b0; h_oif = 2'd0; h_idx = 0;
    end else begin
      mon_exp_ready = (cyc >= busy_until) ? m_grant(req_valid) : '0;
      check("req_ready", req_ready, mon_exp_ready);
      mon_exp_rv = '0;
      if (pend && cyc == pend_cyc + ENTRIES + 2) begin
        m_lookup(pend_ip, h_hit, h_act, h_oif, h_idx);
        mon_exp_rv[pend_port] = 1'b1;
        pend = 1'b0;
      end
      check("resp_valid", resp_valid, mon_exp_rv);
      check("resp_hit", resp_hit, h_hit);
      check("resp_action", resp_action, h_act);
      check("resp_out_if", resp_out_if, h_oif);
      check("resp_index", resp_index, h_idx);
      if (mon_exp_ready != '0) begin
        for (int p = 0; p < N; p++) begin
          if (mon_exp_ready[p]) begin
            pend = 1'b1; pend_cyc = cyc; pend_port = p; pend_ip = req_ip[p*32 +: 32];
            m_last = p; busy_until = cyc + ENTRIES + 2;
            scan_tbl = m_tbl;
          end
        end
      end
      if (cfg_wr_en) begin
        mon_e.valid = cfg_wr_valid; mon_e.prefix = cfg_wr_prefix; mon_e.len = cfg_wr_len;
        mon_e.action = cfg_wr_action; mon_e.out_if = cfg_wr_out_if;
        m_tbl[cfg_wr_addr] = mon_e;
        // Entry k is compared k+2 edges after the handshake negedge; only later writes miss it.
        if (pend && int'(cfg_wr_addr) >= cyc - pend_cyc) scan_tbl[cfg_wr_addr] = mon_e;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic write_entry(input int addr, input bit v, input bit [31:0] pfx, input int len,
                             input bit act, input bit [1:0] oif);
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(addr); cfg_wr_valid = v; cfg_wr_prefix = pfx;
    cfg_wr_len = 6'(len); cfg_wr_action = act; cfg_wr_out_if = oif;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  // Raise a request and return once it is accepted; t_hs is the negedge cycle before the handshake edge.
  task automatic start_req(input int p, input bit [31:0] ip, output int t_hs);
    bit got;
    got = 1'b0; t_hs = 0;
    req_ip[p*32 +: 32] = ip;
    req_valid[p] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin got = 1'b1; t_hs = cyc; end
    end
    check("grant_timeout", got, 1'b1);
    tick();
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int p, input int t_hs, input bit e_hit,
                           input bit e_act, input bit [1:0] e_oif, input int e_idx);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[p]) got = 1'b1;
    end
    check({name, "_timeout"}, got, 1'b1);
    check({name, "_latency"}, cyc - t_hs - 1, 17);
    check({name, "_hit"}, resp_hit, e_hit);
    check({name, "_action"}, resp_action, e_act);
    check({name, "_out_if"}, resp_out_if, e_oif);
    check({name, "_index"}, resp_index, e_idx);
    tick();
  endtask

  task automatic lookup(input string name, input int p, input bit [31:0] ip, input bit e_hit,
                        input bit e_act, input bit [1:0] e_oif, input int e_idx);
    int t;
    start_req(p, ip, t);
    wait_resp(name, p, t, e_hit, e_act, e_oif, e_idx);
  endtask

  // ---------------- directed scenarios ----------------
  int t_hs;
  int n_grant, n_resp, n_pulse;
  int grant_port [4];
  int resp_port [4];
  int resp_cyc [4];
  bit resp_hit_seen [4];
  bit seen;

  initial begin
    reset = 1'b1; req_valid = '0; req_ip = '0; cfg_wr_en = 1'b0; cfg_wr_addr = '0;
    cfg_wr_valid = 1'b0; cfg_wr_prefix = '0; cfg_wr_len = '0; cfg_wr_action = 1'b0;
    cfg_wr_out_if = '0;
    do_reset(3);

    // Reset state.
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 3'b000);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_resp_index", resp_index, 4'd0);
    check("rst_req_ready", req_ready, 3'b000);
    tick();

    // Empty table: miss with all-zero result, 17 cycles after handshake.
    lookup("empty", 0, 32'h0A00_0001, 1'b0, 1'b0, 2'd0, 0);

    // Longest prefix wins.
    write_entry(3, 1'b1, 32'h0A00_0000, 8,  1'b1, 2'd1);
    write_entry(5, 1'b1, 32'h0A01_0000, 16, 1'b1, 2'd2);
    lookup("lpm16", 1, 32'h0A01_0203, 1'b1, 1'b1, 2'd2, 5);
    lookup("lpm8",  2, 32'h0A02_0001, 1'b1, 1'b1, 2'd1, 3);

    // Equal length resolves to the lowest index.
    write_entry(2, 1'b1, 32'hC0A8_0000, 24, 1'b1, 2'd3);
    write_entry(7, 1'b1, 32'hC0A8_0000, 24, 1'b1, 2'd1);
    lookup("tie", 0, 32'hC0A8_0009, 1'b1, 1'b1, 2'd3, 2);

    // len 0 matches everything; len above 32 acts as /32.
    write_entry(9,  1'b1, 32'hDEAD_BEEF, 0,  1'b0, 2'd0);
    write_entry(10, 1'b1, 32'h0102_0304, 40, 1'b1, 2'd2);
    lookup("default", 1, 32'h0808_0808, 1'b1, 1'b0, 2'd0, 9);
    lookup("len40",   2, 32'h0102_0304, 1'b1, 1'b1, 2'd2, 10);
    lookup("len40ne", 0, 32'h0102_0305, 1'b1, 1'b0, 2'd0, 9);

    // Invalidated entry no longer matches.
    write_entry(5, 1'b0, 32'h0A01_0000, 16, 1'b1, 2'd2);
    lookup("inval", 1, 32'h0A01_0203, 1'b1, 1'b1, 2'd1, 3);

    // Writes during a scan: entry 0 already scanned (ignored), entry 14 not yet
    // scanned (seen), entry 8 written on its own compare edge (old value used).
    start_req(2, 32'hAC10_0001, t_hs);
    repeat (3) tick();
    write_entry(0,  1'b1, 32'hAC10_0000, 16, 1'b1, 2'd1);
    write_entry(14, 1'b1, 32'hAC10_0000, 12, 1'b1, 2'd2);
    repeat (3) tick();
    write_entry(8,  1'b1, 32'hAC10_0000, 20, 1'b1, 2'd3);
    wait_resp("midscan", 2, t_hs, 1'b1, 1'b1, 2'd2, 14);
    lookup("after_wr", 0, 32'hAC10_0001, 1'b1, 1'b1, 2'd3, 8);

    // Reset five cycles into a scan aborts it with no response.
    start_req(1, 32'h0A00_0001, t_hs);
    repeat (5) tick();
    do_reset(2);
    n_pulse = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid != '0) n_pulse++;
    end
    check("abort_no_resp", n_pulse, 0);
    tick();

    // All ports requesting continuously: grants 0,1,2,0 after reset, responses 18 cycles apart, table empty.
    req_ip = {32'hC0A8_0009, 32'h0A01_0203, 32'h0A00_0001};
    req_valid = 3'b111;
    n_grant = 0; n_resp = 0;
    for (int i = 0; i < 200 && n_resp < 4; i++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (req_valid[p] && req_ready[p] && n_grant < 4) begin grant_port[n_grant] = p; n_grant++; end
        if (resp_valid[p] && n_resp < 4) begin
          resp_port[n_resp] = p; resp_cyc[n_resp] = cyc; resp_hit_seen[n_resp] = resp_hit; n_resp++;
        end
      end
      if (n_grant == 4 && req_valid != '0) begin @(posedge clk); #1; req_valid = '0; end
    end
    check("rr_resp_count", n_resp, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), grant_port[k], (k == 3) ? 0 : k);
      check($sformatf("rr_resp_port%0d", k), resp_port[k], (k == 3) ? 0 : k);
      check($sformatf("rr_resp_hit%0d", k), resp_hit_seen[k], 1'b0);
      if (k > 0) check($sformatf("rr_spacing%0d", k), resp_cyc[k] - resp_cyc[k-1], 18);
    end
    req_valid = '0;
    tick();

`ifdef FWD_TABLE_STATS_EN
    do_reset(2);
    @(negedge clk);
    check("stat_hit_rst", stat_hit_count, 32'd0);
    check("stat_miss_rst", stat_miss_count, 32'd0);
    tick();
    write_entry(1, 1'b1, 32'h0A00_0000, 8, 1'b1, 2'd1);
    lookup("s_h1", 0, 32'h0A00_0001, 1'b1, 1'b1, 2'd1, 1);
    lookup("s_m1", 1, 32'h0B00_0001, 1'b0, 1'b0, 2'd0, 0);
    lookup("s_h2", 2, 32'h0AFF_0001, 1'b1, 1'b1, 2'd1, 1);
    lookup("s_m2", 0, 32'h0B00_0002, 1'b0, 1'b0, 2'd0, 0);
    lookup("s_h3", 1, 32'h0A12_3456, 1'b1, 1'b1, 2'd1, 1);
    @(negedge clk);
    check("stat_hit", stat_hit_count, 32'd3);
    check("stat_miss", stat_miss_count, 32'd2);
    tick();
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
